// File: rtl/eco32f_regfile_nport.sv
// eco32f register file with NREAD read ports, per-port RAM copies, ID/EX forwarding,
// load-use hazard detection and a post-reset clearing sequencer.
module eco32f_regfile_nport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_if_stall,
    input  logic                          i_id_stall,
    input  logic                          i_ex_stall,
    input  logic                          i_ex_flush,
    input  logic [NREAD*ADDR_WIDTH-1:0]   i_if_raddr,
    input  logic [NREAD*ADDR_WIDTH-1:0]   i_id_raddr,
    input  logic [NREAD*ADDR_WIDTH-1:0]   i_ex_raddr,
    input  logic [ADDR_WIDTH-1:0]         i_ex_rd_addr,
    input  logic                          i_ex_rd_we,
    input  logic                          i_ex_rd_load,
    input  logic [DATA_WIDTH-1:0]         i_mem_result,
    output logic [ADDR_WIDTH-1:0]         o_mem_rd_addr,
    output logic                          o_mem_rd_we,
    input  logic [ADDR_WIDTH-1:0]         i_wb_addr,
    input  logic                          i_wb_we,
    input  logic [DATA_WIDTH-1:0]         i_wb_data,
    output logic [NREAD*DATA_WIDTH-1:0]   o_id_rdata,
    output logic [NREAD*DATA_WIDTH-1:0]   o_ex_rdata,
    output logic                          o_ld_hazard,
    output logic                          o_init_busy
);

    localparam int AW    = ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int NREGS = 2 ** ADDR_WIDTH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_cnt, w_cnt_next;
    logic            w_init_busy;
    logic            w_re;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [DW-1:0]   w_wr_data;
    logic            r_rf_valid;
    logic [DW-1:0]   r_wb_hold;
    logic [NREAD-1:0] w_hz_match;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_init_busy  = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_busy = 1'b1;
                if (r_cnt == AW'(NREGS - 1))
                    w_state_next = S_RUN;
                else
                    w_cnt_next = r_cnt + AW'(1);
            end
            default: ;
        endcase
    end

    // One shared write port feeds every RAM copy: clearing writes in INIT, writeback in RUN.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = i_wb_addr;
        w_wr_data = i_wb_data;
        if (w_init_busy) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_cnt;
            w_wr_data = '0;
        end else begin
            w_wr_en = i_wb_we && !((ZERO_REG != 0) && (i_wb_addr == '0));
        end
    end

    assign w_re        = !i_if_stall && !w_init_busy;
    assign o_init_busy = w_init_busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rf_valid    <= 1'b0;
            r_wb_hold     <= '0;
            o_mem_rd_addr <= '0;
            o_mem_rd_we   <= 1'b0;
        end else begin
            r_rf_valid <= w_re;
            if (i_wb_we)
                r_wb_hold <= i_wb_data;
            if (!i_ex_stall)
                o_mem_rd_addr <= i_ex_rd_addr;
            if (i_ex_flush)
                o_mem_rd_we <= 1'b0;
            else if (!i_ex_stall)
                o_mem_rd_we <= i_ex_rd_we;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [DW-1:0] r_ram [NREGS];
        logic [DW-1:0] r_ram_q;
        logic [DW-1:0] r_id_hold;
        logic [DW-1:0] r_ex_lat;
        logic          r_id_zero, r_ex2id, r_mem2id;
        logic          r_ex2ex, r_mem2ex, r_wb2ex;
        logic [DW-1:0] w_id_data, w_ex_data;
        logic [AW-1:0] w_if_addr, w_id_addr, w_ex_addr;

        assign w_if_addr = i_if_raddr[p*AW +: AW];
        assign w_id_addr = i_id_raddr[p*AW +: AW];
        assign w_ex_addr = i_ex_raddr[p*AW +: AW];

        // Write-first: a same-cycle write to the read address bypasses the array.
        always_ff @(posedge i_clk) begin
            if (w_wr_en)
                r_ram[w_wr_addr] <= w_wr_data;
            if (w_re)
                r_ram_q <= (w_wr_en && (w_wr_addr == w_if_addr)) ? w_wr_data : r_ram[w_if_addr];
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                r_id_zero <= 1'b0;
                r_ex2id   <= 1'b0;
                r_mem2id  <= 1'b0;
                r_id_hold <= '0;
            end else begin
                r_id_zero <= (ZERO_REG != 0) && (w_if_addr == '0);
                r_ex2id   <= i_ex_rd_we && (i_ex_rd_addr == w_if_addr);
                r_mem2id  <= o_mem_rd_we && (o_mem_rd_addr == w_if_addr);
                r_id_hold <= w_id_data;
            end
        end

        always_comb begin
            w_id_data = r_id_hold;
            if (r_rf_valid) begin
                if (r_id_zero)
                    w_id_data = '0;
                else if (r_ex2id)
                    w_id_data = i_mem_result;
                else if (r_mem2id)
                    w_id_data = i_wb_data;
                else
                    w_id_data = r_ram_q;
            end
        end

        // A stalled ID drops the WB bypass since wb_hold keeps tracking newer writebacks.
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                r_ex_lat <= '0;
                r_ex2ex  <= 1'b0;
                r_mem2ex <= 1'b0;
                r_wb2ex  <= 1'b0;
            end else if (!i_id_stall) begin
                r_ex_lat <= w_id_data;
                r_ex2ex  <= i_ex_rd_we && (i_ex_rd_addr == w_id_addr);
                r_mem2ex <= o_mem_rd_we && (o_mem_rd_addr == w_id_addr);
                r_wb2ex  <= i_wb_we && (i_wb_addr == w_id_addr);
            end else begin
                r_wb2ex  <= 1'b0;
            end
        end

        always_comb begin
            w_ex_data = r_ex_lat;
            if ((ZERO_REG != 0) && (w_ex_addr == '0))
                w_ex_data = '0;
            else if (r_ex2ex)
                w_ex_data = i_mem_result;
            else if (r_mem2ex)
                w_ex_data = i_wb_data;
            else if (r_wb2ex)
                w_ex_data = r_wb_hold;
        end

        assign o_id_rdata[p*DW +: DW] = w_id_data;
        assign o_ex_rdata[p*DW +: DW] = w_ex_data;
        assign w_hz_match[p]          = (i_ex_rd_addr == w_id_addr);
    end

    assign o_ld_hazard = !w_init_busy && i_ex_rd_we && i_ex_rd_load &&
                         ((ZERO_REG == 0) || (i_ex_rd_addr != '0)) && (|w_hz_match);

endmodule
